// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - EX-side inputs and MEM-side outputs of the EX/MEM pipeline boundary
interface ex_mem_stage_if;
  logic        StallM;
  logic        FlushM;
  logic        ValidE;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        BranchE;
  logic        JumpE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  funct3E;
  logic [31:0] ALUResultE;
  logic        ZeroE;
  logic        NegativeE;
  logic        OverFlowE;
  logic        CarryE;
  logic [31:0] WriteDataE;
  logic [4:0]  RDE;
  logic [31:0] PCPlus4E;
  logic [31:0] PCTargetE;

  logic        PCSrcE;
  logic        ValidM;
  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
  logic [4:0]  RDM;
  logic        MisalignM;
  logic [31:0] BranchCnt;
  logic [31:0] TakenCnt;

  modport master (
    output StallM, FlushM, ValidE, RegWriteE, MemWriteE, BranchE, JumpE,
           ResultSrcE, funct3E, ALUResultE, ZeroE, NegativeE, OverFlowE,
           CarryE, WriteDataE, RDE, PCPlus4E, PCTargetE,
    input  PCSrcE, ValidM, RegWriteM, MemWriteM, ResultSrcM, ALUResultM,
           WriteDataM, PCPlus4M, RDM, MisalignM, BranchCnt, TakenCnt
  );

  modport slave (
    input  StallM, FlushM, ValidE, RegWriteE, MemWriteE, BranchE, JumpE,
           ResultSrcE, funct3E, ALUResultE, ZeroE, NegativeE, OverFlowE,
           CarryE, WriteDataE, RDE, PCPlus4E, PCTargetE,
    output PCSrcE, ValidM, RegWriteM, MemWriteM, ResultSrcM, ALUResultM,
           WriteDataM, PCPlus4M, RDM, MisalignM, BranchCnt, TakenCnt
  );
endinterface

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - RV32I EX/MEM boundary: branch resolution, PC redirect, M registers, branch stats
module ex_mem_stage (
  input  logic          clk,
  input  logic          rst,
  ex_mem_stage_if.slave bus
);

  logic        cond;
  logic        go;
  logic        take;
  logic        mis;

  logic        valid_q, valid_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_write_q, mem_write_d;
  logic [1:0]  result_src_q, result_src_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [4:0]  rd_q, rd_d;
  logic        misalign_q, misalign_d;
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;

  // Flags come from the ALU computing rs1 - rs2; Carry=1 means no borrow.
  always_comb begin
    cond = 1'b0;
    case (bus.funct3E)
      3'b000:  cond = bus.ZeroE;
      3'b001:  cond = ~bus.ZeroE;
      3'b100:  cond = bus.NegativeE ^ bus.OverFlowE;
      3'b101:  cond = ~(bus.NegativeE ^ bus.OverFlowE);
      3'b110:  cond = ~bus.CarryE;
      3'b111:  cond = bus.CarryE;
      default: cond = 1'b0;
    endcase
  end

  assign go   = bus.ValidE & ~bus.StallM & ~bus.FlushM & ~rst;
  assign take = go & (bus.JumpE | (bus.BranchE & cond));
  assign mis  = take & (bus.PCTargetE[1:0] != 2'b00);

  assign bus.PCSrcE = take & ~mis;

  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    result_src_d = result_src_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    pc_plus4_d   = pc_plus4_q;
    rd_d         = rd_q;
    misalign_d   = misalign_q;
    // Flush only kills the control bits; data regs keep their last value.
    if (bus.FlushM) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      result_src_d = 2'b00;
      misalign_d   = 1'b0;
    end else if (!bus.StallM) begin
      valid_d      = bus.ValidE;
      reg_write_d  = bus.RegWriteE & bus.ValidE & ~mis;
      mem_write_d  = bus.MemWriteE & bus.ValidE & ~mis;
      result_src_d = bus.ResultSrcE;
      alu_result_d = bus.ALUResultE;
      write_data_d = bus.WriteDataE;
      pc_plus4_d   = bus.PCPlus4E;
      rd_d         = bus.RDE;
      misalign_d   = mis;
    end
    // go already excludes stall and flush, so the counters freeze with them.
    branch_cnt_d = branch_cnt_q + 32'(go & (bus.BranchE | bus.JumpE));
    taken_cnt_d  = taken_cnt_q + 32'(take);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      alu_result_q <= 32'd0;
      write_data_q <= 32'd0;
      pc_plus4_q   <= 32'd0;
      rd_q         <= 5'd0;
      misalign_q   <= 1'b0;
      branch_cnt_q <= 32'd0;
      taken_cnt_q  <= 32'd0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
      misalign_q   <= misalign_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign bus.ValidM     = valid_q;
  assign bus.RegWriteM  = reg_write_q;
  assign bus.MemWriteM  = mem_write_q;
  assign bus.ResultSrcM = result_src_q;
  assign bus.ALUResultM = alu_result_q;
  assign bus.WriteDataM = write_data_q;
  assign bus.PCPlus4M   = pc_plus4_q;
  assign bus.RDM        = rd_q;
  assign bus.MisalignM  = misalign_q;
  assign bus.BranchCnt  = branch_cnt_q;
  assign bus.TakenCnt   = taken_cnt_q;

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory boundary of the RV32I five-stage pipeline, directly downstream of the execute-stage ALU. Each cycle it resolves the branch or jump in EX from the ALU flags and raises a same-cycle PC redirect. It registers the ALU result, store data and control into the MEM stage, with stall, flush and misaligned-target handling. It also keeps free-running branch statistics counters.

## Interface
- No parameters; all widths are fixed for RV32I.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- StallM  input  1  hold all M registers; the EX instruction does not advance.
- FlushM  input  1  kill the EX instruction; insert a bubble into M.
- ValidE  input  1  the EX slot holds a real instruction.
- RegWriteE, MemWriteE, BranchE, JumpE  input  1 each  decoded controls.
- ResultSrcE  input  2  writeback select, passed through.
- funct3E  input  3  branch condition.
- ALUResultE  input  32  ALU Result.
- ZeroE, NegativeE, OverFlowE, CarryE  input  1 each  ALU flags.
- WriteDataE  input  32  forwarded rs2, used as store data.
- RDE  input  5  destination register.
- PCPlus4E, PCTargetE  input  32  link address and branch/jump target.
- PCSrcE  output  1  combinational redirect to PCTargetE.
- ValidM, RegWriteM, MemWriteM  output  1 each  registered.
- ResultSrcM  output  2  registered.
- ALUResultM, WriteDataM, PCPlus4M  output  32 each  registered.
- RDM  output  5  registered.
- MisalignM  output  1  registered instruction-address-misaligned flag.
- BranchCnt, TakenCnt  output  32 each  resolved and taken control-transfer counters.

## Operation
- Condition `cond` by funct3E, with flags taken from the ALU subtract operation:
  - 000 BEQ: Zero.
  - 001 BNE: ~Zero.
  - 100 BLT: Negative ^ OverFlow.
  - 101 BGE: ~(Negative ^ OverFlow).
  - 110 BLTU: ~Carry. Carry=1 means no borrow, i.e. A >= B unsigned.
  - 111 BGEU: Carry.
  - 010 and 011 are reserved and give cond=0.
- `go` = ValidE & ~StallM & ~FlushM & ~rst.
- `take` = go & (JumpE | (BranchE & cond)).
- `mis` = take & (PCTargetE[1:0] != 0).
- PCSrcE = take & ~mis. A misaligned target never redirects.
- Register update priority: rst > FlushM > StallM > normal.
  - rst: every output register clears to 0, including both counters.
  - FlushM (with or without StallM): ValidM, RegWriteM, MemWriteM, MisalignM and ResultSrcM clear to 0. Data registers (ALUResultM, WriteDataM, PCPlus4M, RDM) hold. Counters hold.
  - StallM: every M register and both counters hold.
  - Normal: ValidM<=ValidE and MisalignM<=mis. RegWriteM<=RegWriteE&ValidE&~mis and MemWriteM<=MemWriteE&ValidE&~mis. ResultSrcM<=ResultSrcE and the data registers load from their E inputs.
- Counters:
  - BranchCnt increments when go & (BranchE|JumpE).
  - TakenCnt increments when take, including misaligned takes.
  - Both wrap modulo 2^32 from 0xFFFFFFFF to 0.
- An invalid EX slot (ValidE=0) loads a bubble: no write enables, no redirect, no count.

## Timing
- Latency is 1 cycle from E inputs to M outputs. PCSrcE is valid in the same cycle as its E inputs.
- PCSrcE has a purely combinational path from the flags, ValidE, StallM and FlushM. It carries no registered state.
- Every output reads 0 after any rst cycle. PCSrcE is 0 during rst.
- Stall: for N cycles of StallM=1, the M outputs are bit-identical to the pre-stall values and PCSrcE=0. The EX instruction is resolved on the first cycle with StallM=0.
- Simultaneous StallM and FlushM: flush wins and a bubble enters M.
- Asserting rst mid-stall or mid-flush clears all state on that edge. The first post-reset edge with ValidE=1 behaves normally.

## Test plan
- Reset: drive rst=1 for 2 cycles with random inputs -> all M outputs and counters read 0, and PCSrcE=0.
- BEQ taken: A=B=5 gives ZeroE=1; BranchE=1, funct3=000, PCTargetE=0x100 -> PCSrcE=1 the same cycle, then BranchCnt=1 and TakenCnt=1 next cycle. With funct3=001 and the same flags -> PCSrcE=0, BranchCnt=2, TakenCnt=1.
- Signed and unsigned compares:
  - BLT with A=0x80000000, B=1 gives result 0x7FFFFFFF, N=0, V=1 -> taken.
  - BLTU with A=0xFFFFFFFF, B=1 gives Carry=1 -> not taken.
  - BGEU with the same operands -> taken.
- Misaligned JAL: JumpE=1, RegWriteE=1, PCTargetE=0x102 -> PCSrcE=0, then next cycle MisalignM=1, RegWriteM=0, ValidM=1, TakenCnt incremented.
- Stall then flush:
  - Load an ALU op with ALUResultE=0xDEADBEEF, then hold StallM=1 for 3 cycles while the inputs change -> M outputs stay at 0xDEADBEEF, PCSrcE=0 and the counters are frozen.
  - Then assert StallM=1 and FlushM=1 together -> ValidM=0, RegWriteM=0, and ALUResultM still reads 0xDEADBEEF.
- Counter wrap: force 2^32 resolved branches, or preload via a test hook -> BranchCnt goes 0xFFFFFFFF to 0x00000000 with no other side effects.
